// File: rtl/io_bus_responder_pkg.sv
// Shared bus widths, peripheral map and decode helpers for io_bus_responder.
package io_bus_responder_pkg;

    localparam int IO_BUS_WIDTH_ADDR = 32;
    localparam int IO_BUS_WIDTH_DATA = 32;
    localparam int IO_BUS_WIDTH_CTRL = 1;

    localparam logic [31:0] PERIPH_BASE_DEFAULT = 32'hFFFF_F000;

    // Byte offsets inside the 4 KiB peripheral window.
    localparam logic [11:0] OFF_DIGIT  = 12'h000;
    localparam logic [11:0] OFF_LED    = 12'h060;
    localparam logic [11:0] OFF_SWITCH = 12'h070;
    localparam logic [11:0] OFF_CYCLE  = 12'h080;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_DIGIT,
        REG_LED,
        REG_SWITCH,
        REG_CYCLE
    } periph_reg_e;

    typedef enum logic {
        SRC_RAM,
        SRC_PERIPH
    } rd_src_e;

    // Word-granular decode: the two byte-lane bits never reach this function.
    function automatic periph_reg_e decode_reg(input logic [9:0] word_off);
        periph_reg_e sel;
        sel = REG_NONE;
        if (word_off == OFF_DIGIT[11:2])  sel = REG_DIGIT;
        if (word_off == OFF_LED[11:2])    sel = REG_LED;
        if (word_off == OFF_SWITCH[11:2]) sel = REG_SWITCH;
        if (word_off == OFF_CYCLE[11:2])  sel = REG_CYCLE;
        return sel;
    endfunction

endpackage

// File: rtl/io_bus_responder_dram_word_bank.sv
// Single-port read-first word RAM, inferable as block RAM; not reset.
// Read data is registered: one cycle after the index is presented.
module dram_word_bank #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] index,
    input  logic [31:0]   wd,
    output logic [31:0]   rd
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rd_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[index] <= wd;
        end
        rd_q <= mem[index];
    end

    assign rd = rd_q;

endmodule

// File: rtl/io_bus_responder.sv
// Bus responder: RAM plus DIGIT/LED/SWITCH/CYCLE peripheral registers.
// Latency: read data one cycle after the address; writes commit at the edge. No backpressure.
module io_bus_responder
    import io_bus_responder_pkg::*;
#(
    parameter int          RAM_DEPTH_WORDS = 4096,
    parameter logic [31:0] PERIPH_BASE     = PERIPH_BASE_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [IO_BUS_WIDTH_ADDR-1:0] bus_addr,
    input  logic [IO_BUS_WIDTH_DATA-1:0] bus_wd,
    input  logic                         bus_we,
    input  logic [IO_BUS_WIDTH_CTRL-1:0] bus_ctrl,
    output logic [IO_BUS_WIDTH_DATA-1:0] bus_rd,
    input  logic [23:0]                  sw,
    output logic [23:0]                  led,
    output logic [31:0]                  digit
);

    localparam int RAM_AW = $clog2(RAM_DEPTH_WORDS);

    logic              periph_sel;
    periph_reg_e       reg_sel;
    logic              wr_en;
    logic              ram_we;
    logic [31:0]       ram_rd;

    logic [31:0] digit_d,     digit_q;
    logic [23:0] led_d,       led_q;
    logic [31:0] cycle_d,     cycle_q;
    logic [23:0] sw_meta_d,   sw_meta_q;
    logic [23:0] sw_sync_d,   sw_sync_q;
    logic [31:0] periph_rd_d, periph_rd_q;
    rd_src_e     rd_src_d,    rd_src_q;

    logic unused_ok;
    assign unused_ok = ^bus_ctrl;

    always_comb begin
        periph_sel = (bus_addr >= PERIPH_BASE);
        reg_sel    = periph_sel ? decode_reg(bus_addr[11:2]) : REG_NONE;
        wr_en      = bus_we & rst_n;
        ram_we     = wr_en & ~periph_sel;
        rd_src_d   = periph_sel ? SRC_PERIPH : SRC_RAM;

        // Captured from the pre-write register values, giving read-first behaviour.
        periph_rd_d = 32'h0;
        case (reg_sel)
            REG_DIGIT:  periph_rd_d = digit_q;
            REG_LED:    periph_rd_d = {8'h0, led_q};
            REG_SWITCH: periph_rd_d = {8'h0, sw_sync_q};
            REG_CYCLE:  periph_rd_d = cycle_q;
            default:    periph_rd_d = 32'h0;
        endcase

        digit_d = digit_q;
        led_d   = led_q;
        cycle_d = cycle_q + 32'd1;
        if (wr_en) begin
            case (reg_sel)
                REG_DIGIT: digit_d = bus_wd;
                REG_LED:   led_d   = bus_wd[23:0];
                REG_CYCLE: cycle_d = 32'h0;
                default:   ;
            endcase
        end

        sw_meta_d = sw;
        sw_sync_d = sw_meta_q;
    end

    // Reset parks the read mux on the peripheral path, whose capture clears,
    // so bus_rd reads zero even though RAM output is never reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digit_q     <= 32'h0;
            led_q       <= 24'h0;
            cycle_q     <= 32'h0;
            sw_meta_q   <= 24'h0;
            sw_sync_q   <= 24'h0;
            periph_rd_q <= 32'h0;
            rd_src_q    <= SRC_PERIPH;
        end else begin
            digit_q     <= digit_d;
            led_q       <= led_d;
            cycle_q     <= cycle_d;
            sw_meta_q   <= sw_meta_d;
            sw_sync_q   <= sw_sync_d;
            periph_rd_q <= periph_rd_d;
            rd_src_q    <= rd_src_d;
        end
    end

    dram_word_bank #(
        .DEPTH (RAM_DEPTH_WORDS),
        .AW    (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .index (bus_addr[RAM_AW+1:2]),
        .wd    (bus_wd),
        .rd    (ram_rd)
    );

    assign bus_rd = (rd_src_q == SRC_PERIPH) ? periph_rd_q : ram_rd;
    assign led    = led_q;
    assign digit  = digit_q;

endmodule

// File: tb/tb_io_bus_responder.sv
// Randomized and directed bench for io_bus_responder against a transaction-level model.
module tb_io_bus_responder;

    localparam logic [31:0] BASE = 32'hFFFF_F000;

    logic        clk;
    logic        rst_n;
    logic [31:0] bus_addr;
    logic [31:0] bus_wd;
    logic        bus_we;
    logic [0:0]  bus_ctrl;
    logic [31:0] bus_rd;
    logic [23:0] sw;
    logic [23:0] led;
    logic [31:0] digit;

    int vectors;
    int miscompares;

    // Model state: RAM words that have been written, registers, switch history per edge.
    logic [31:0] ram_m [int];
    logic [31:0] digit_m;
    logic [23:0] led_m;
    logic [31:0] cyc_m;
    logic [23:0] sw_hist [$];

    assign bus_ctrl = bus_we;

    io_bus_responder #(
        .RAM_DEPTH_WORDS (4096),
        .PERIPH_BASE     (BASE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus_addr (bus_addr),
        .bus_wd   (bus_wd),
        .bus_we   (bus_we),
        .bus_ctrl (bus_ctrl),
        .bus_rd   (bus_rd),
        .sw       (sw),
        .led      (led),
        .digit    (digit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Applies one access across one rising edge, updates the model and returns
    // the bus_rd value due just after that edge; returns at edge + 1.
    task automatic do_cycle(input logic r, input logic [31:0] a, input logic w,
                            input logic [31:0] d, output logic [31:0] exp_rd,
                            output logic known);
        logic [11:0] off;
        int          idx;
        rst_n    = r;
        bus_addr = a;
        bus_we   = w;
        bus_wd   = d;
        @(posedge clk);
        known  = 1'b1;
        exp_rd = 32'h0;
        if (!r) begin
            digit_m = 32'h0;
            led_m   = 24'h0;
            cyc_m   = 32'h0;
            sw_hist = {24'h0, 24'h0};
        end else begin
            if (a >= BASE) begin
                off = a[11:0] & 12'hFFC;
                case (off)
                    12'h000: exp_rd = digit_m;
                    12'h060: exp_rd = {8'h0, led_m};
                    12'h070: exp_rd = {8'h0, sw_hist[$-1]};
                    12'h080: exp_rd = cyc_m;
                    default: exp_rd = 32'h0;
                endcase
                if (w && off == 12'h000) digit_m = d;
                if (w && off == 12'h060) led_m = d[23:0];
                if (w && off == 12'h080) cyc_m = 32'h0;
                else                     cyc_m = cyc_m + 1;
            end else begin
                idx = int'(a[13:2]);
                if (ram_m.exists(idx)) exp_rd = ram_m[idx];
                else known = 1'b0;
                if (w) ram_m[idx] = d;
                cyc_m = cyc_m + 1;
            end
            sw_hist.push_back(sw);
            if (sw_hist.size() > 4) void'(sw_hist.pop_front());
        end
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] e;
        logic        k;
        for (int i = 0; i < 2; i++) begin
            do_cycle(1'b0, 32'h0, 1'b0, 32'h0, e, k);
        end
        vectors++;
        if (bus_rd !== 32'h0) begin miscompares++; $display("FAIL reset_bus_rd: got %h want %h", bus_rd, 32'h0); end
        vectors++;
        if (led !== 24'h0) begin miscompares++; $display("FAIL reset_led: got %h want %h", led, 24'h0); end
        vectors++;
        if (digit !== 32'h0) begin miscompares++; $display("FAIL reset_digit: got %h want %h", digit, 32'h0); end
        do_cycle(1'b1, BASE + 32'h80, 1'b0, 32'h0, e, k);
        vectors++;
        if (bus_rd !== 32'h0) begin miscompares++; $display("FAIL reset_first_cycle: got %h want %h", bus_rd, 32'h0); end
        do_cycle(1'b1, BASE + 32'h80, 1'b0, 32'h0, e, k);
        vectors++;
        if (bus_rd !== 32'h1) begin miscompares++; $display("FAIL reset_second_cycle: got %h want %h", bus_rd, 32'h1); end
    endtask

    task automatic test_ram_basic();
        logic [31:0] e;
        logic        k;
        do_cycle(1'b1, 32'h10, 1'b1, 32'hDEADBEEF, e, k);
        do_cycle(1'b1, 32'h10, 1'b0, 32'h0, e, k);
        vectors++;
        if (bus_rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL ram_basic: got %h want %h", bus_rd, 32'hDEADBEEF); end
        do_cycle(1'b1, 32'h13, 1'b0, 32'h0, e, k);
        vectors++;
        if (bus_rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL ram_byte_lane_ignored: got %h want %h", bus_rd, 32'hDEADBEEF); end
    endtask

    task automatic test_read_first();
        logic [31:0] e;
        logic        k;
        do_cycle(1'b1, 32'h20, 1'b1, 32'h11223344, e, k);
        do_cycle(1'b1, 32'h20, 1'b1, 32'h55667788, e, k);
        vectors++;
        if (bus_rd !== 32'h11223344) begin miscompares++; $display("FAIL read_first_old: got %h want %h", bus_rd, 32'h11223344); end
        do_cycle(1'b1, 32'h20, 1'b0, 32'h0, e, k);
        vectors++;
        if (bus_rd !== 32'h55667788) begin miscompares++; $display("FAIL read_first_new: got %h want %h", bus_rd, 32'h55667788); end
        do_cycle(1'b1, BASE, 1'b1, 32'h0BADF00D, e, k);
        do_cycle(1'b1, BASE, 1'b1, 32'h12345678, e, k);
        vectors++;
        if (bus_rd !== 32'h0BADF00D) begin miscompares++; $display("FAIL read_first_digit: got %h want %h", bus_rd, 32'h0BADF00D); end
        vectors++;
        if (digit !== 32'h12345678) begin miscompares++; $display("FAIL digit_port: got %h want %h", digit, 32'h12345678); end
    endtask

    task automatic test_led_switch();
        logic [31:0] e;
        logic        k;
        do_cycle(1'b1, BASE + 32'h60, 1'b1, 32'hFFFFFFFF, e, k);
        vectors++;
        if (led !== 24'hFFFFFF) begin miscompares++; $display("FAIL led_port: got %h want %h", led, 24'hFFFFFF); end
        do_cycle(1'b1, BASE + 32'h60, 1'b0, 32'h0, e, k);
        vectors++;
        if (bus_rd !== 32'h00FFFFFF) begin miscompares++; $display("FAIL led_readback: got %h want %h", bus_rd, 32'h00FFFFFF); end
        do_cycle(1'b1, BASE + 32'h70, 1'b1, 32'hFFFFFFFF, e, k);
        sw = 24'hA5A5A5;
        for (int i = 0; i < 3; i++) begin
            do_cycle(1'b1, BASE + 32'h70, 1'b0, 32'h0, e, k);
            vectors++;
            if (bus_rd !== e) begin miscompares++; $display("FAIL switch_sync_%0d: got %h want %h", i, bus_rd, e); end
        end
        vectors++;
        if (bus_rd !== 32'h00A5A5A5) begin miscompares++; $display("FAIL switch_value: got %h want %h", bus_rd, 32'h00A5A5A5); end
    endtask

    task automatic test_cycle();
        logic [31:0] e;
        logic        k;
        do_cycle(1'b1, BASE + 32'h80, 1'b1, 32'h5A5A5A5A, e, k);
        for (int i = 0; i < 5; i++) begin
            do_cycle(1'b1, BASE + 32'h80, 1'b0, 32'h0, e, k);
            vectors++;
            if (bus_rd !== 32'(i)) begin miscompares++; $display("FAIL cycle_seq_%0d: got %h want %h", i, bus_rd, 32'(i)); end
        end
        dut.cycle_q = 32'hFFFF_FFFF;
        cyc_m       = 32'hFFFF_FFFF;
        do_cycle(1'b1, BASE + 32'h80, 1'b0, 32'h0, e, k);
        vectors++;
        if (bus_rd !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL cycle_max: got %h want %h", bus_rd, 32'hFFFF_FFFF); end
        do_cycle(1'b1, BASE + 32'h80, 1'b0, 32'h0, e, k);
        vectors++;
        if (bus_rd !== 32'h0) begin miscompares++; $display("FAIL cycle_wrap: got %h want %h", bus_rd, 32'h0); end
    endtask

    task automatic test_alias();
        logic [31:0] e;
        logic        k;
        do_cycle(1'b1, 32'h4010, 1'b1, 32'hCAFE0001, e, k);
        do_cycle(1'b1, 32'h0010, 1'b0, 32'h0, e, k);
        vectors++;
        if (bus_rd !== 32'hCAFE0001) begin miscompares++; $display("FAIL ram_alias: got %h want %h", bus_rd, 32'hCAFE0001); end
        do_cycle(1'b1, BASE + 32'h04, 1'b1, 32'hFFFFFFFF, e, k);
        do_cycle(1'b1, BASE + 32'h04, 1'b0, 32'h0, e, k);
        vectors++;
        if (bus_rd !== 32'h0) begin miscompares++; $display("FAIL unmapped_read: got %h want %h", bus_rd, 32'h0); end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] e;
        logic        k;
        do_cycle(1'b1, 32'h30, 1'b1, 32'h600DCAFE, e, k);
        do_cycle(1'b1, BASE + 32'h60, 1'b1, 32'h00123456, e, k);
        do_cycle(1'b1, BASE, 1'b1, 32'h87654321, e, k);
        do_cycle(1'b0, 32'h30, 1'b1, 32'hBAD0BAD0, e, k);
        vectors++;
        if (bus_rd !== 32'h0) begin miscompares++; $display("FAIL mid_reset_bus_rd: got %h want %h", bus_rd, 32'h0); end
        vectors++;
        if (led !== 24'h0) begin miscompares++; $display("FAIL mid_reset_led: got %h want %h", led, 24'h0); end
        vectors++;
        if (digit !== 32'h0) begin miscompares++; $display("FAIL mid_reset_digit: got %h want %h", digit, 32'h0); end
        do_cycle(1'b1, BASE + 32'h80, 1'b0, 32'h0, e, k);
        vectors++;
        if (bus_rd !== 32'h0) begin miscompares++; $display("FAIL mid_reset_cycle: got %h want %h", bus_rd, 32'h0); end
        do_cycle(1'b1, 32'h30, 1'b0, 32'h0, e, k);
        vectors++;
        if (bus_rd !== 32'h600DCAFE) begin miscompares++; $display("FAIL mid_reset_ram_kept: got %h want %h", bus_rd, 32'h600DCAFE); end
    endtask

    task automatic test_random();
        logic [31:0] e;
        logic        k;
        logic [31:0] a;
        logic [11:0] offs [6];
        offs = '{12'h000, 12'h060, 12'h070, 12'h080, 12'h004, 12'h100};
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 15) == 0) sw = 24'($urandom);
            if ($urandom_range(0, 9) < 6) begin
                a = (32'($urandom_range(0, 3)) << 14) | (32'($urandom_range(0, 15)) << 2)
                    | 32'($urandom_range(0, 3));
            end else begin
                a = BASE | 32'(offs[$urandom_range(0, 5)]) | 32'($urandom_range(0, 3));
            end
            do_cycle(1'b1, a, 1'($urandom_range(0, 1)), $urandom, e, k);
            if (k) begin
                vectors++;
                if (bus_rd !== e) begin miscompares++; $display("FAIL random_rd_%0d addr %h: got %h want %h", n, a, bus_rd, e); end
            end
            vectors++;
            if (led !== led_m || digit !== digit_m) begin
                miscompares++;
                $display("FAIL random_regs_%0d: led %h digit %h want %h %h", n, led, digit, led_m, digit_m);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bus_addr    = 32'h0;
        bus_wd      = 32'h0;
        bus_we      = 1'b0;
        sw          = 24'h0;
        digit_m     = 32'h0;
        led_m       = 24'h0;
        cyc_m       = 32'h0;
        sw_hist     = {24'h0, 24'h0};
        @(negedge clk);
        test_reset();
        test_ram_basic();
        test_read_first();
        test_led_switch();
        test_cycle();
        test_alias();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
